vga_mem_ctrl: RTL and testbench

- Sequences reads from the frame-image ROM and delivers a continuous pixel stream to the VGA colour output stage.
- Prefetches packed memory words into a small word FIFO, hiding the ROM's 1-cycle read latency.
- Unpacks each word into pixels, LSB pixel first.
- Sits between the VGA timing generator (frame_start, pixel request) and the ROM (addr, rd_en, data).

---
 rtl/vga_mem_pkg.sv | 26 ++
 rtl/vga_mem_ctrl_fifo.sv | 78 +++++++
 rtl/vga_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_vga_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mem_pkg.sv
// -----------------------------------------------------------------------------
// vga_mem_pkg
// Shared types and default sizing for the VGA frame-memory controller.
//   mem_ctrl_state_t : controller FSM states (IDLE, FILL, RUN, DRAIN)
//   WORD_W           : ROM word width in bits
//   PIX_W            : bits per pixel (must divide WORD_W)
//   FRAME_WORDS      : ROM words per frame (160x120 at 4 px/word)
//   FIFO_DEPTH       : prefetch word FIFO depth (power of 2, >= 2)
//   PIX_PER_WORD     : pixels packed in one ROM word
// -----------------------------------------------------------------------------
package vga_mem_pkg;

    localparam int WORD_W       = 16;
    localparam int PIX_W        = 4;
    localparam int FRAME_WORDS  = 4800;
    localparam int FIFO_DEPTH   = 4;
    localparam int PIX_PER_WORD = WORD_W / PIX_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } mem_ctrl_state_t;

endpackage

// File: rtl/vga_mem_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// sync_word_fifo
// Small synchronous word FIFO with a combinational head (first-word
// fall-through), so the pixel unpacker can read the head word in the same
// cycle it becomes available.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : synchronous clear of pointers and count (wins over push/pop)
//   push, din  : write a word (ignored when full unless popping the same cycle)
//   pop        : discard the head word (ignored when empty)
//   dout       : current head word
//   count      : number of stored words
//   empty/full : occupancy flags
// -----------------------------------------------------------------------------
module sync_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only safe when the head is leaving this cycle.
    assign do_push = push && (!full || do_pop);

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/vga_mem_ctrl.sv
// -----------------------------------------------------------------------------
// vga_mem_ctrl
// Reads packed pixel words from the frame ROM, prefetches them into a small
// word FIFO (hiding the ROM's 1-cycle read latency) and unpacks each word into
// a pixel stream, LSB pixel first.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   frame_start_in  : 1-cycle pulse; (re)starts a frame from ROM address 0
//   pix_rd_in       : consumer takes the current pixel this cycle
//   pix_dat_out     : current pixel (0 when not valid)
//   pix_valid_out   : pix_dat_out is valid
//   mem_addr_out    : ROM address
//   mem_rd_en_out   : ROM read enable
//   mem_dat_in      : ROM data, valid one cycle after mem_rd_en_out
//   underflow_out   : sticky, pixel requested while none was available
// FRAME_WORDS is expected to be at least FIFO_DEPTH.
// -----------------------------------------------------------------------------
module vga_mem_ctrl #(
    parameter int WORD_W      = vga_mem_pkg::WORD_W,
    parameter int PIX_W       = vga_mem_pkg::PIX_W,
    parameter int FRAME_WORDS = vga_mem_pkg::FRAME_WORDS,
    parameter int ADDR_W      = $clog2(FRAME_WORDS),
    parameter int FIFO_DEPTH  = vga_mem_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_in,
    input  logic              pix_rd_in,
    output logic [PIX_W-1:0]  pix_dat_out,
    output logic              pix_valid_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_rd_en_out,
    input  logic [WORD_W-1:0] mem_dat_in,
    output logic              underflow_out
);

    import vga_mem_pkg::mem_ctrl_state_t;
    import vga_mem_pkg::IDLE;
    import vga_mem_pkg::FILL;
    import vga_mem_pkg::RUN;
    import vga_mem_pkg::DRAIN;

    localparam int PIX_PER_WORD = WORD_W / PIX_W;
    localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    mem_ctrl_state_t   state_reg;
    mem_ctrl_state_t   state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [IDX_W-1:0]  pix_idx_reg;
    logic              inflight_reg;
    logic              underflow_reg;

    logic [WORD_W-1:0] head_word;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic              issuing;
    logic              serving;
    logic              rd_en;
    logic              last_read;
    logic              pix_valid;
    logic              advance;
    logic              pop;
    logic              push;
    logic [PIX_W-1:0]  head_pix [PIX_PER_WORD];

    // ------------------------------------------------------------------
    // Read issue: credit counts words stored plus the one possibly in
    // flight; a pop this cycle is only credited once the count updates.
    // ------------------------------------------------------------------
    assign issuing   = (state_reg == FILL) || (state_reg == RUN);
    assign serving   = (state_reg == RUN)  || (state_reg == DRAIN);
    assign rd_en     = issuing && !fifo_full &&
                       ((int'(fifo_count) + int'(inflight_reg)) < FIFO_DEPTH);
    assign last_read = rd_en && (addr_reg == ADDR_W'(FRAME_WORDS - 1));

    // The ROM word arriving this cycle belongs to the old frame on a restart.
    assign push      = inflight_reg && !frame_start_in;

    // ------------------------------------------------------------------
    // Pixel unpacking, LSB pixel first.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_unpack
        assign head_pix[gi] = head_word[gi*PIX_W +: PIX_W];
    end

    assign pix_valid = serving && !fifo_empty;
    assign advance   = pix_rd_in && pix_valid;
    assign pop       = advance && (pix_idx_reg == IDX_W'(PIX_PER_WORD - 1));

    assign pix_valid_out = pix_valid;
    assign pix_dat_out   = pix_valid ? head_pix[pix_idx_reg] : '0;
    assign mem_addr_out  = addr_reg;
    assign mem_rd_en_out = rd_en;
    assign underflow_out = underflow_reg;

    sync_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (frame_start_in),
        .push  (push),
        .din   (mem_dat_in),
        .pop   (pop),
        .dout  (head_word),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = IDLE;
            // No pops happen in FILL, so the push landing on DEPTH-1 fills it.
            FILL:  if (push && (fifo_count == CNT_W'(FIFO_DEPTH - 1))) state_next = RUN;
            RUN:   if (last_read) state_next = DRAIN;
            DRAIN: if (fifo_empty && !inflight_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_start_in) begin
            state_next = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            pix_idx_reg   <= '0;
            inflight_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // A read issued during the restart cycle is dropped as well,
            // otherwise its old-frame data would land after the flush.
            inflight_reg <= rd_en && !frame_start_in;
            if (frame_start_in) begin
                addr_reg      <= '0;
                pix_idx_reg   <= '0;
                underflow_reg <= 1'b0;
            end else begin
                // Address holds at the last word instead of running past it.
                if (rd_en && !last_read) begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
                if (pop) begin
                    pix_idx_reg <= '0;
                end else if (advance) begin
                    pix_idx_reg <= pix_idx_reg + IDX_W'(1);
                end
                if (pix_rd_in && !pix_valid && serving) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_mem_ctrl.sv
module tb_vga_mem_ctrl;

    localparam int WW  = 16;
    localparam int PW  = 4;
    localparam int FW  = 4800;
    localparam int FD  = 4;
    localparam int AW  = $clog2(FW);
    localparam int PPW = WW / PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          pix_rd;
    logic [PW-1:0] pix_dat;
    logic          pix_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [WW-1:0] mem_dat = '0;
    logic          underflow;

    always #5 clk = ~clk;

    vga_mem_ctrl #(
        .WORD_W      (WW),
        .PIX_W       (PW),
        .FRAME_WORDS (FW),
        .ADDR_W      (AW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start_in (frame_start),
        .pix_rd_in      (pix_rd),
        .pix_dat_out    (pix_dat),
        .pix_valid_out  (pix_valid),
        .mem_addr_out   (mem_addr),
        .mem_rd_en_out  (mem_rd_en),
        .mem_dat_in     (mem_dat),
        .underflow_out  (underflow)
    );

    // Frame ROM with a registered read.
    logic [WW-1:0] rom [FW];
    always @(posedge clk) begin
        if (mem_rd_en) mem_dat <= rom[mem_addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of words requested from the ROM, each
    // tagged with the cycle it becomes readable (issue + 2). Phases:
    // 0 idle, 1 filling, 2 serving pixels.
    // ------------------------------------------------------------------
    typedef struct {
        logic [WW-1:0] word;
        int            ready;
    } ent_t;

    ent_t q[$];
    int   phase    = 0;
    int   issued   = 0;
    int   popped   = 0;
    int   m_idx    = 0;
    bit   m_uf     = 0;
    bit   model_ok = 0;
    int   cyc      = 0;
    int   fs_cyc   = 0;

    // observations for directed checks
    int        frame_reads = 0;
    int        last_addr   = 0;
    logic [7:0] rd_mask    = '0;
    int        first_rel   = -1;
    int        first_pix   = 0;

    bit            exp_valid;
    bit            exp_rd;
    bit            adv;
    int            old_phase;
    int            rel;
    int            nready;
    logic [WW-1:0] hw;
    ent_t          e;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
            phase = 0; issued = 0; popped = 0; m_idx = 0; m_uf = 0;
            frame_reads = 0;
            model_ok = 1;
        end else if (model_ok) begin
            exp_valid = (phase == 2) && (q.size() > 0) && (q[0].ready <= cyc);
            exp_rd    = (phase != 0) && (issued < FW) && (q.size() < FD);

            chk("pix_valid", int'(pix_valid), int'(exp_valid));
            if (exp_valid) begin
                hw = q[0].word;
                chk("pix_dat", int'(pix_dat), int'(hw[m_idx*PW +: PW]));
            end
            chk("rd_en", int'(mem_rd_en), int'(exp_rd));
            if (mem_rd_en && exp_rd) chk("rd_addr", int'(mem_addr), issued);
            chk("underflow", int'(underflow), int'(m_uf));

            rel = cyc - fs_cyc;
            if (mem_rd_en) begin
                frame_reads++;
                last_addr = int'(mem_addr);
                if (rel >= 1 && rel <= 7) rd_mask[rel] = 1'b1;
            end
            if (pix_valid && first_rel < 0) begin
                first_rel = rel;
                first_pix = int'(pix_dat);
            end

            adv = exp_valid && pix_rd;
            if (frame_start) begin
                q.delete();
                issued = 0; popped = 0; m_idx = 0; m_uf = 0;
                phase = 1; fs_cyc = cyc;
                frame_reads = 0; rd_mask = '0; first_rel = -1;
            end else begin
                old_phase = phase;
                if (old_phase == 2 && pix_rd && !exp_valid) m_uf = 1;
                // one empty serving cycle after the last pixel, then idle
                if (old_phase == 2 && popped == FW) phase = 0;
                if (adv) begin
                    if (m_idx == PPW - 1) begin
                        void'(q.pop_front());
                        popped++;
                        m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
                if (exp_rd) begin
                    e.word  = rom[issued];
                    e.ready = cyc + 2;
                    q.push_back(e);
                    issued++;
                end
                if (phase == 1) begin
                    nready = 0;
                    foreach (q[i]) if (q[i].ready <= cyc + 1) nready++;
                    if (nready >= FD) phase = 2;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // mode 0: continuous read until the frame is consumed, then stop.
    // mode 1: random reads, FILL pulses, a 20-cycle stall, then keep
    //         reading after the frame ends to hit the empty DRAIN cycle.
    task automatic run_frame(input int mode);
        int n = 0;
        while (phase != 0 && n < 40000) begin
            if (mode == 0)                 pix_rd = (popped < FW);
            else if (popped >= FW)         pix_rd = 1'b1;
            else if (n < 4)                pix_rd = 1'b1;
            else if (n >= 3000 && n < 3020) pix_rd = 1'b0;
            else                           pix_rd = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        if (phase != 0) chk("frame_timeout", n, -1);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, int'(pix_valid), 0);
        chk({tag, "_dat"},   int'(pix_dat),   0);
        chk({tag, "_addr"},  int'(mem_addr),  0);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_uf"},    int'(underflow), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; frame_start = 1'b0; pix_rd = 1'b0;
        for (int k = 0; k < FW; k++) rom[k] = WW'(k);
        repeat (3) tick();
        rst_n = 1'b1;
        check_outputs_zero("reset");
        $display("[TB] reset: outputs checked");
        tick();

        // Fill latency with mem[k]=k, continuous consumption
        start_frame();
        run_frame(0);
        chk("fill_latency", first_rel, FD + 2);
        chk("fill_rd_mask", int'(rd_mask), 8'b0001_1110);
        chk("t1_reads", frame_reads, FW);
        chk("t1_last_addr", last_addr, FW - 1);
        $display("[TB] frame k-pattern: reads=%0d first_valid=%0d", frame_reads, first_rel);

        // Continuous stream of 0xDCBA words
        for (int k = 0; k < FW; k++) rom[k] = 16'hDCBA;
        repeat (5) tick();
        start_frame();
        run_frame(0);
        chk("t2_reads", frame_reads, FW);
        chk("t2_last_addr", last_addr, FW - 1);
        chk("t2_underflow", int'(underflow), 0);
        $display("[TB] frame DCBA: reads=%0d last_addr=%0d", frame_reads, last_addr);

        // Random data and consumer with a stall; underflow in DRAIN
        for (int k = 0; k < FW; k++) rom[k] = WW'($urandom);
        repeat (5) tick();
        start_frame();
        run_frame(1);
        repeat (3) tick();
        pix_rd = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("uf_held", int'(underflow), 1);
        $display("[TB] frame random: reads=%0d underflow=%0d", frame_reads, underflow);

        // Mid-frame restart with a read in flight
        tick();
        rom[0] = 16'h0005;
        rom[1000] = 16'h000A;
        start_frame();
        pix_rd = 1'b1;
        n = 0;
        while (issued < 1000 && n < 8000) begin tick(); n++; end
        if (issued < 1000) chk("restart_timeout", n, -1);
        start_frame();
        @(negedge clk);
        chk("restart_uf_clear", int'(underflow), 0);
        n = 0;
        while (first_rel < 0 && n < 100) begin tick(); n++; end
        chk("restart_first_pix", first_pix, 5);
        chk("restart_latency", first_rel, FD + 2);
        $display("[TB] restart: first_pix=%0d latency=%0d", first_pix, first_rel);

        // Reset mid-RUN
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outputs_zero("midrst");
        repeat (10) tick();
        chk("midrst_no_reads", frame_reads, 0);
        $display("[TB] reset mid-run: reads after reset=%0d", frame_reads);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
